motor_duty_sequencer: RTL
=========================

Name: motor_duty_sequencer

Overview:
- Sits between the host command registers and the motor driver's `duty_cycle` input.
- Slew-limits the commanded duty cycle (soft start and soft stop) and gates the drive.
- Monitors the filtered hall-sensor code for invalid codes and for stall.
- On a fault it forces duty to zero and latches a fault code until the host clears it.

Parameters:
- DUTY_WIDTH, 8, width of duty command/output; equals `DUTY_CYCLE_WIDTH`.
- RAMP_DIV, 256, clocks per 1-LSB duty step; legal range 1 to 65535.
- STALL_CYCLES, 2000000, clocks without a hall edge in RUN before a stall fault; legal range 2 to 2^24-1.
- HALL_FILTER, 4, consecutive identical synchronized hall samples required to accept a new code; legal range 1 to 15.

Ports:
- clock, input, 1, system clock.
- reset_n, input, 1, asynchronous active-low reset.
- enable, input, 1, host run request; level-sensitive.
- duty_cmd, input, DUTY_WIDTH, target duty while enable=1.
- hall, input, 3, raw hall sensors; asynchronous to clock.
- fault_clear, input, 1, single-cycle pulse; clears a latched fault.
- duty_out, output, DUTY_WIDTH, duty to the motor driver.
- drive_en, output, 1, 1 while in RAMP or RUN.
- hall_q, output, 3, filtered hall code.
- fault, output, 1, latched fault flag.
- fault_code, output, 2, 00 none / 01 invalid hall / 10 stall / 11 reserved.
- busy, output, 1, 1 whenever state is not IDLE.

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE.
  - duty_out=0, drive_en=0, fault=0, fault_code=00, busy=0, hall_q=000.
  - All counters and synchronizer flops clear.
  - Deassertion is synchronized internally with a 2-flop reset release.
- Hall input path:
  - 2-flop synchronizer, then filter.
  - hall_q updates when the synchronized value differs from hall_q and has been stable HALL_FILTER consecutive clocks.
  - Latency from a raw change to hall_q is 2+HALL_FILTER clocks.
  - hall_edge is a 1-clock strobe when hall_q changes.
- Target: target = enable ? duty_cmd : 0, evaluated every clock.
- Ramp tick:
  - A counter runs 0..RAMP_DIV-1 in RAMP and wraps; tick fires at terminal count.
  - The counter clears on entry to RAMP.
  - On tick, duty_out moves 1 LSB toward target: +1 if below, -1 if above.
  - duty_out never overshoots and never wraps.
  - If target changes mid-ramp, ramping continues toward the new target with no counter restart.
- State machine:
  - IDLE:
    - duty_out=0.
    - enable=1 and duty_cmd!=0 -> RAMP.
    - enable=1 with duty_cmd=0 stays IDLE.
  - RAMP:
    - duty_out==target and target!=0 -> RUN.
    - duty_out==0 and target==0 -> IDLE.
  - RUN:
    - target!=duty_out -> RAMP; this covers a duty change and enable dropping to 0.
    - The stall counter is active only in RUN.
  - FAULT:
    - duty_out=0 on the next clock, with no ramp-down; drive_en=0.
    - Exit to IDLE only on fault_clear=1 while enable=0.
    - fault_clear while enable=1 is ignored.
- Faults (checked in RAMP and RUN only):
  - Invalid hall: hall_q==000 or 111 -> FAULT with code 01.
  - Stall: the counter clears on hall_edge and on RUN entry, and increments otherwise in RUN. Reaching STALL_CYCLES -> FAULT with code 10; the counter saturates and does not wrap.
  - Simultaneous invalid-hall and stall: code 01 wins.
  - A fault takes priority over every other transition in the same cycle.
  - fault and fault_code are set on FAULT entry and cleared on FAULT exit.
- Stall counter width: clog2(STALL_CYCLES+1).
- duty_out is registered; transition-to-output latency is 1 clock.

Decomposition:
- Shared package/header (extends `Phase_Driver.vh`):
  - `DUTY_CYCLE_WIDTH`.
  - State encodings: IDLE=0, RAMP=1, RUN=2, FAULT=3.
  - fault_code constants `FAULT_NONE`, `FAULT_HALL`, `FAULT_STALL`.
  - `HALL_INVALID_LO`=000 and `HALL_INVALID_HI`=111.
- One sub-module, hall_filter:
  - Contains the synchronizer, the stability counter, and the hall_edge strobe.
  - Reused by the Motor_Driver front end later.
- The FSM, ramp counter and stall counter stay in the top module.

Test Plan (bench overrides: RAMP_DIV=4, STALL_CYCLES=100, HALL_FILTER=2; hall rotates 101->100->110->010->011->001 every 40 clocks unless stated):
- Soft start: enable=1, duty_cmd=8'h10 from IDLE -> drive_en=1 next clock; duty_out steps +1 every 4 clocks; reaches 8'h10 after 64 clocks; state RUN.
- Retarget/stop: in RUN at 8'h10, set duty_cmd=8'h08 -> RAMP down to 8'h08 in 32 clocks then RUN. Then enable=0 -> reaches 0 in 32 clocks, then IDLE, busy=0.
- Invalid hall: in RUN, force hall=3'b111 for 5 clocks -> fault=1, fault_code=01, duty_out=0 and drive_en=0 within 2+2+1 clocks of the change.
- Stall: in RUN, freeze hall=3'b101 -> FAULT with code 10 exactly 100 clocks after the last hall_q edge.
- Clear rules: in FAULT, pulse fault_clear with enable=1 -> stays FAULT. Pulse with enable=0 -> IDLE, fault=0, fault_code=00.
- Async reset: assert reset_n=0 mid-RAMP at duty_out=8'h07 -> all outputs zero immediately, without waiting for a clock edge. After release, IDLE and hall_q=000 with no spurious fault.

Source files
------------

// File: rtl/motor_duty_sequencer_pkg.sv
// Shared definitions for the motor duty sequencer and its hall front end.
// Covers the duty width, state encodings, fault codes and invalid hall codes.
package motor_duty_sequencer_pkg;

  localparam int unsigned DUTY_CYCLE_WIDTH = 8;
  localparam int unsigned HALL_WIDTH       = 3;
  localparam int unsigned FAULT_CODE_WIDTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RAMP  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  typedef logic [FAULT_CODE_WIDTH-1:0] fault_code_t;

  localparam fault_code_t FAULT_NONE  = 2'b00;
  localparam fault_code_t FAULT_HALL  = 2'b01;
  localparam fault_code_t FAULT_STALL = 2'b10;

  localparam logic [HALL_WIDTH-1:0] HALL_INVALID_LO = 3'b000;
  localparam logic [HALL_WIDTH-1:0] HALL_INVALID_HI = 3'b111;

  typedef struct packed {
    logic        fault;
    fault_code_t code;
  } fault_status_t;

  function automatic logic hall_is_invalid(input logic [HALL_WIDTH-1:0] code);
    return (code == HALL_INVALID_LO) || (code == HALL_INVALID_HI);
  endfunction

endpackage

// File: rtl/motor_duty_sequencer_hall_filter.sv
// Hall front end: 2-flop synchronizer, stability filter and a change strobe.
// hall_edge_c_o is high in the cycle whose closing edge loads a new hall_q_o.
module hall_filter
  import motor_duty_sequencer_pkg::*;
#(
  parameter int unsigned HALL_FILTER = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [HALL_WIDTH-1:0] hall_i,
  output logic [HALL_WIDTH-1:0] hall_q_o,
  output logic                  hall_edge_c_o
);

  localparam int unsigned CNT_W = 5;

  logic [HALL_WIDTH-1:0] sync1_q, sync2_q;
  logic [HALL_WIDTH-1:0] cand_q, cand_d;
  logic [HALL_WIDTH-1:0] hall_q, hall_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  accept_c;

  // Count consecutive samples of a candidate that differs from the accepted code.
  always_comb begin
    cand_d   = sync2_q;
    cnt_d    = '0;
    hall_d   = hall_q;
    accept_c = 1'b0;
    if (sync2_q != hall_q) begin
      cnt_d = (cand_q == sync2_q) ? cnt_q + CNT_W'(1) : CNT_W'(1);
      if (cnt_d >= CNT_W'(HALL_FILTER)) begin
        accept_c = 1'b1;
        hall_d   = sync2_q;
        cnt_d    = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      hall_q  <= '0;
    end else begin
      sync1_q <= hall_i;
      sync2_q <= sync1_q;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      hall_q  <= hall_d;
    end
  end

  assign hall_q_o      = hall_q;
  assign hall_edge_c_o = accept_c;

endmodule

// File: rtl/motor_duty_sequencer.sv
// Slew-limited duty sequencer with hall validity and stall supervision.
// Faults force duty to zero and latch a code until cleared with enable low.
module motor_duty_sequencer
  import motor_duty_sequencer_pkg::*;
#(
  parameter int unsigned DUTY_WIDTH   = DUTY_CYCLE_WIDTH,
  parameter int unsigned RAMP_DIV     = 256,
  parameter int unsigned STALL_CYCLES = 2000000,
  parameter int unsigned HALL_FILTER  = 4
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic [DUTY_WIDTH-1:0]       duty_cmd,
  input  logic [HALL_WIDTH-1:0]       hall,
  input  logic                        fault_clear,
  output logic [DUTY_WIDTH-1:0]       duty_out,
  output logic                        drive_en,
  output logic [HALL_WIDTH-1:0]       hall_q,
  output logic                        fault,
  output logic [FAULT_CODE_WIDTH-1:0] fault_code,
  output logic                        busy
);

  localparam int unsigned RAMP_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int unsigned STALL_W = $clog2(STALL_CYCLES + 1);

  state_e                state_q, state_d;
  logic [DUTY_WIDTH-1:0] duty_q, duty_d;
  logic [RAMP_W-1:0]     ramp_cnt_q, ramp_cnt_d;
  logic [STALL_W-1:0]    stall_cnt_q, stall_cnt_d;
  fault_status_t         status_q, status_d;
  logic                  drive_en_q, drive_en_d;
  logic                  busy_q, busy_d;
  logic [1:0]            rst_sync_q;
  logic                  rst_n_int;

  logic [HALL_WIDTH-1:0] hall_filt;
  logic                  hall_edge_c;
  logic [DUTY_WIDTH-1:0] target_c;
  logic                  hall_bad_c, ramp_tick_c, stall_hit_c;
  logic [STALL_W-1:0]    stall_inc_c;
  fault_code_t           fault_sel_c;

  // Assert asynchronously, release two clocks after reset_n rises.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_int = rst_sync_q[1];

  hall_filter #(
    .HALL_FILTER(HALL_FILTER)
  ) u_hall_filter (
    .clk_i        (clock),
    .rst_ni       (rst_n_int),
    .hall_i       (hall),
    .hall_q_o     (hall_filt),
    .hall_edge_c_o(hall_edge_c)
  );

  assign target_c    = enable ? duty_cmd : '0;
  assign hall_bad_c  = hall_is_invalid(hall_filt);
  assign ramp_tick_c = (state_q == ST_RAMP) && (ramp_cnt_q == RAMP_W'(RAMP_DIV - 1));
  assign stall_inc_c = (stall_cnt_q == STALL_W'(STALL_CYCLES)) ? stall_cnt_q
                                                                : stall_cnt_q + STALL_W'(1);
  // The counter would reach STALL_CYCLES on this edge.
  assign stall_hit_c = !hall_edge_c && (stall_cnt_q >= STALL_W'(STALL_CYCLES - 1));

  always_ff @(posedge clock or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q     <= ST_IDLE;
      duty_q      <= '0;
      ramp_cnt_q  <= '0;
      stall_cnt_q <= '0;
      status_q    <= '0;
      drive_en_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      duty_q      <= duty_d;
      ramp_cnt_q  <= ramp_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      status_q    <= status_d;
      drive_en_q  <= drive_en_d;
      busy_q      <= busy_d;
    end
  end

  // Next state; faults outrank every other transition.
  always_comb begin
    state_d     = state_q;
    fault_sel_c = FAULT_NONE;
    case (state_q)
      ST_IDLE: if (enable && (duty_cmd != '0)) state_d = ST_RAMP;
      ST_RAMP: begin
        if (hall_bad_c) begin
          state_d     = ST_FAULT;
          fault_sel_c = FAULT_HALL;
        end else if ((duty_q == target_c) && (target_c != '0)) begin
          state_d = ST_RUN;
        end else if ((duty_q == '0) && (target_c == '0)) begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (hall_bad_c) begin
          state_d     = ST_FAULT;
          fault_sel_c = FAULT_HALL;
        end else if (stall_hit_c) begin
          state_d     = ST_FAULT;
          fault_sel_c = FAULT_STALL;
        end else if (target_c != duty_q) begin
          state_d = ST_RAMP;
        end
      end
      ST_FAULT: if (fault_clear && !enable) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Registered outputs and counters, all keyed off the next state.
  always_comb begin
    duty_d      = duty_q;
    ramp_cnt_d  = '0;
    stall_cnt_d = '0;
    status_d    = '0;
    drive_en_d  = (state_d == ST_RAMP) || (state_d == ST_RUN);
    busy_d      = (state_d != ST_IDLE);

    if ((state_q == ST_RAMP) && (state_d == ST_RAMP))
      ramp_cnt_d = ramp_tick_c ? '0 : ramp_cnt_q + RAMP_W'(1);

    if (state_q == ST_RUN)
      stall_cnt_d = hall_edge_c ? '0 : stall_inc_c;

    if ((state_d == ST_FAULT) || (state_d == ST_IDLE)) begin
      duty_d = '0;
    end else if (ramp_tick_c) begin
      if (duty_q < target_c)      duty_d = duty_q + DUTY_WIDTH'(1);
      else if (duty_q > target_c) duty_d = duty_q - DUTY_WIDTH'(1);
    end

    if (state_d == ST_FAULT) begin
      if (state_q != ST_FAULT) begin
        status_d.fault = 1'b1;
        status_d.code  = fault_sel_c;
      end else begin
        status_d = status_q;
      end
    end
  end

  assign duty_out   = duty_q;
  assign drive_en   = drive_en_q;
  assign hall_q     = hall_filt;
  assign fault      = status_q.fault;
  assign fault_code = status_q.code;
  assign busy       = busy_q;

endmodule
